// File: rtl/alu_sys_pkg.sv
// alu_sys_pkg: controller states, command bytes and ALU function codes
package alu_sys_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        ALU_WAIT,
        SEND_LO,
        SEND_HI
    } state_t;

    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] FUN_ADD   = 4'd0;
    localparam logic [3:0] FUN_SUB   = 4'd1;
    localparam logic [3:0] FUN_MUL   = 4'd2;
    localparam logic [3:0] FUN_DIV   = 4'd3;
    localparam logic [3:0] FUN_AND   = 4'd4;
    localparam logic [3:0] FUN_OR    = 4'd5;
    localparam logic [3:0] FUN_NAND  = 4'd6;
    localparam logic [3:0] FUN_NOR   = 4'd7;
    localparam logic [3:0] FUN_XOR   = 4'd8;
    localparam logic [3:0] FUN_XNOR  = 4'd9;
    localparam logic [3:0] FUN_CMPEQ = 4'd10;
    localparam logic [3:0] FUN_CMPGT = 4'd11;
    localparam logic [3:0] FUN_CMPLT = 4'd12;
    localparam logic [3:0] FUN_SHR   = 4'd13;
    localparam logic [3:0] FUN_SHL   = 4'd14;

    // States in which an incoming RX byte cannot be consumed
    function automatic logic is_busy(state_t s);
        return s inside {ALU_RUN, ALU_WAIT, SEND_LO, SEND_HI};
    endfunction

endpackage

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: holds the ALU result and sends it low byte first over valid/ready
module alu_result_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic [OUT_WIDTH-1:0]  result_i,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  tx_vld_o,
    output logic                  lo_done_o,
    output logic                  done_o
);

    logic [OUT_WIDTH-1:0] res_q;
    logic                 hi_q;
    logic                 vld_q;
    logic                 acc;

    assign acc       = vld_q && tx_ready_i;
    assign lo_done_o = acc && !hi_q;
    assign done_o    = acc && hi_q;
    assign tx_vld_o  = vld_q;
    assign tx_data_o = hi_q ? res_q[OUT_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];

    // Load on start, advance to the high byte on first acceptance, release on second
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q <= '0;
            hi_q  <= 1'b0;
            vld_q <= 1'b0;
        end else if (start_i) begin
            res_q <= result_i;
            hi_q  <= 1'b0;
            vld_q <= 1'b1;
        end else if (acc) begin
            hi_q  <= 1'b1;
            vld_q <= !hi_q;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses RX command frames, drives the ALU and returns its result on TX
module alu_cmd_ctrl
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  ALU_CLK_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_READY,
    output logic                  CMD_ERR,
    output logic                  RX_OVERRUN
);

    localparam int CW = $clog2(TIMEOUT);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [3:0]            fun_q, fun_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  en_q, clk_en_q;
    logic                  err_q, err_d;
    logic                  ovr_q, ovr_d;
    logic                  ser_start, lo_done, hi_done;

    assign ser_start  = (state_q == ALU_WAIT) && ALU_OUT_VALID;
    assign ALU_A      = a_q;
    assign ALU_B      = b_q;
    assign ALU_FUN    = fun_q;
    assign ALU_EN     = en_q;
    assign ALU_CLK_EN = clk_en_q;
    assign CMD_ERR    = err_q;
    assign RX_OVERRUN = ovr_q;

    // Next-state, operand capture, timeout and error/overrun detection
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        ovr_d   = RX_D_VLD && is_busy(state_q);
        case (state_q)
            IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))
                    state_d = GET_A;
                else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP))
                    state_d = GET_FUN;
                else
                    err_d = 1'b1;
            end
            GET_A: if (RX_D_VLD) begin
                a_d     = RX_P_DATA;
                state_d = GET_B;
            end
            GET_B: if (RX_D_VLD) begin
                b_d     = RX_P_DATA;
                state_d = GET_FUN;
            end
            GET_FUN: if (RX_D_VLD) begin
                fun_d   = RX_P_DATA[3:0];
                state_d = ALU_RUN;
            end
            ALU_RUN: begin
                cnt_d   = '0;
                state_d = ALU_WAIT;
            end
            ALU_WAIT: begin
                if (ALU_OUT_VALID)
                    state_d = SEND_LO;
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else
                    cnt_d = cnt_q + 1'b1;
            end
            SEND_LO: if (lo_done) state_d = SEND_HI;
            SEND_HI: if (hi_done) state_d = IDLE;
        endcase
    end

    // State and registered outputs; ALU strobes are decoded from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            clk_en_q <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            fun_q    <= fun_d;
            cnt_q    <= cnt_d;
            en_q     <= state_d == ALU_RUN;
            clk_en_q <= state_d inside {ALU_RUN, ALU_WAIT};
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    alu_result_serializer #(
        .DATA_WIDTH(DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .start_i   (ser_start),
        .result_i  (ALU_OUT),
        .tx_ready_i(TX_READY),
        .tx_data_o (TX_P_DATA),
        .tx_vld_o  (TX_D_VLD),
        .lo_done_o (lo_done),
        .done_o    (hi_done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: randomized frame-level check of alu_cmd_ctrl against a transaction model
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  ALU_A, ALU_B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, ALU_CLK_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VALID;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_READY = 1'b0;
    logic        CMD_ERR, RX_OVERRUN;

    int total = 0, bad = 0;
    int cyc = 0, en_cnt = 0, err_cnt = 0, ovr_cnt = 0, en_cyc = 0, err_cyc = 0;
    int alu_dly = 1, rdy_mode = 1;
    logic [7:0] cap_a, cap_b;
    logic [3:0] cap_f;
    logic [7:0] tx_q[$];
    logic [7:0] ref_a = '0, ref_b = '0;
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    alu_cmd_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .ALU_A        (ALU_A),
        .ALU_B        (ALU_B),
        .ALU_FUN      (ALU_FUN),
        .ALU_EN       (ALU_EN),
        .ALU_CLK_EN   (ALU_CLK_EN),
        .ALU_OUT      (ALU_OUT),
        .ALU_OUT_VALID(ALU_OUT_VALID),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_READY     (TX_READY),
        .CMD_ERR      (CMD_ERR),
        .RX_OVERRUN   (RX_OVERRUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return (b == 0) ? 16'h0 : 16'(a / b);
            4'd4:    return {8'h0, a & b};
            4'd5:    return {8'h0, a | b};
            4'd6:    return {8'h0, ~(a & b)};
            4'd7:    return {8'h0, ~(a | b)};
            4'd8:    return {8'h0, a ^ b};
            4'd9:    return {8'h0, ~(a ^ b)};
            4'd10:   return (a == b) ? 16'd1 : 16'd0;
            4'd11:   return (a > b) ? 16'd1 : 16'd0;
            4'd12:   return (a < b) ? 16'd1 : 16'd0;
            4'd13:   return 16'(a >> 1);
            4'd14:   return 16'(a) << 1;
            default: return 16'h0;
        endcase
    endfunction

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
        step(gap);
    endtask

    task automatic wait_tx();
        int t = 0;
        while (!TX_D_VLD && t < 100) begin
            step();
            t++;
        end
        if (!TX_D_VLD) chk("wait_tx_vld", 32'(TX_D_VLD), 1);
    endtask

    // ALU stand-in: answers dly cycles after sampling ALU_EN (dly 0 never answers)
    initial begin
        logic [15:0] r;
        ALU_OUT = '0;
        ALU_OUT_VALID = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (ALU_EN && !RST) begin
                en_cnt++;
                en_cyc = cyc;
                cap_a  = ALU_A;
                cap_b  = ALU_B;
                cap_f  = ALU_FUN;
                r      = alu_fn(ALU_A, ALU_B, ALU_FUN);
                if (alu_dly > 0) begin
                    repeat (alu_dly) @(posedge CLK);
                    #1;
                    ALU_OUT       = r;
                    ALU_OUT_VALID = 1'b1;
                    @(posedge CLK);
                    #1;
                    ALU_OUT_VALID = 1'b0;
                    ALU_OUT       = 16'($urandom);
                end
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (rdy_mode == 1) TX_READY = ($urandom_range(0, 2) != 0);
    end

    // Observe pulses, accepted TX bytes and hold-while-stalled behaviour
    always @(negedge CLK) begin
        if (!RST) begin
            if (CMD_ERR) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (RX_OVERRUN) ovr_cnt++;
            if (TX_D_VLD && TX_READY) tx_q.push_back(TX_P_DATA);
            if (pv && !pr && TX_D_VLD) chk("tx_hold", 32'(TX_P_DATA), 32'(pd));
            if (ALU_EN) chk("clk_en_during_en", 32'(ALU_CLK_EN), 1);
        end
        pv = TX_D_VLD;
        pr = TX_READY;
        pd = TX_P_DATA;
    end

    task automatic frame(input bit nop, input logic [7:0] a, input logic [7:0] b, input logic [7:0] f,
                         input int dly, input int gap, input bit stray);
        int e0, er0, ov0, t;
        logic [15:0] exp;
        bit good;
        e0 = en_cnt;
        er0 = err_cnt;
        ov0 = ovr_cnt;
        tx_q.delete();
        alu_dly = dly;
        if (!nop) begin
            ref_a = a;
            ref_b = b;
        end
        exp  = alu_fn(ref_a, ref_b, f[3:0]);
        good = dly >= 1 && dly <= 16;
        if (nop) put(8'hDD, gap);
        else begin
            put(8'hCC, gap);
            put(a, gap);
            put(b, gap);
        end
        put(f, stray ? 0 : gap);
        if (stray) put(8'($urandom), 0);
        t = 0;
        while (((good && tx_q.size() < 2) || (!good && err_cnt == er0)) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) chk("frame_done", 0, 1);
        chk("en_pulses", 32'(en_cnt - e0), 1);
        chk("alu_a", 32'(cap_a), 32'(ref_a));
        chk("alu_b", 32'(cap_b), 32'(ref_b));
        chk("alu_fun", 32'(cap_f), 32'(f[3:0]));
        if (good) begin
            chk("cmd_err_none", 32'(err_cnt - er0), 0);
            chk("tx_count", 32'(tx_q.size()), 2);
            if (tx_q.size() == 2) begin
                chk("tx_lo", 32'(tx_q[0]), 32'(exp[7:0]));
                chk("tx_hi", 32'(tx_q[1]), 32'(exp[15:8]));
            end
        end else begin
            chk("timeout_err", 32'(err_cnt - er0), 1);
            chk("timeout_cycles", 32'(err_cyc - en_cyc), 17);
            chk("timeout_clk_en", 32'(ALU_CLK_EN), 0);
            step(3);
            chk("timeout_no_tx", 32'(tx_q.size()), 0);
        end
        chk("overrun", 32'(ovr_cnt - ov0), 32'(stray));
    endtask

    task automatic bad_cmd(input logic [7:0] c);
        int e0, er0;
        e0 = en_cnt;
        er0 = err_cnt;
        put(c, 0);
        chk("bad_err_next", 32'(CMD_ERR), 1);
        step(2);
        chk("bad_err_once", 32'(err_cnt - er0), 1);
        chk("bad_no_en", 32'(en_cnt - e0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int ov0;
        logic [15:0] exp;
        logic [7:0] c;
        step(3);
        chk("rst_data", {4'h0, ALU_A, ALU_B, ALU_FUN, TX_P_DATA}, 0);
        chk("rst_flags", {27'h0, ALU_EN, ALU_CLK_EN, TX_D_VLD, CMD_ERR, RX_OVERRUN}, 0);
        RST = 1'b0;
        step(2);

        frame(0, 8'h12, 8'h34, 8'h00, 1, 0, 0);
        frame(0, 8'hFF, 8'hFF, 8'h02, 1, 1, 0);
        frame(1, 8'h00, 8'h00, 8'h01, 1, 0, 0);
        chk("nop_keeps_a", 32'(ALU_A), 8'hFF);
        bad_cmd(8'hAB);
        frame(0, 8'h05, 8'h03, 8'h00, 1, 0, 0);

        rdy_mode = 0;
        TX_READY = 1'b0;
        tx_q.delete();
        ov0 = ovr_cnt;
        alu_dly = 1;
        ref_a = 8'h21;
        ref_b = 8'h43;
        exp = alu_fn(ref_a, ref_b, 4'd8);
        put(8'hCC, 0);
        put(8'h21, 0);
        put(8'h43, 0);
        put(8'h08, 0);
        wait_tx();
        for (int i = 0; i < 10; i++) begin
            chk("stall_vld", 32'(TX_D_VLD), 1);
            chk("stall_data", 32'(TX_P_DATA), 32'(exp[7:0]));
            if (i == 4) put(8'hCC, 0);
            else step();
        end
        chk("stall_overrun", 32'(ovr_cnt - ov0), 1);
        chk("stall_no_tx", 32'(tx_q.size()), 0);
        rdy_mode = 1;
        for (int t = 0; t < 100 && tx_q.size() < 2; t++) step();
        chk("stall_tx_count", 32'(tx_q.size()), 2);
        if (tx_q.size() == 2) begin
            chk("stall_tx_lo", 32'(tx_q[0]), 32'(exp[7:0]));
            chk("stall_tx_hi", 32'(tx_q[1]), 32'(exp[15:8]));
        end

        frame(0, 8'h40, 8'h02, 8'h03, 0, 0, 0);
        frame(0, 8'h09, 8'h07, 8'h01, 16, 0, 0);
        frame(1, 8'h00, 8'h00, 8'hF2, 17, 0, 0);
        frame(0, 8'h33, 8'h11, 8'h00, 1, 0, 1);

        rdy_mode = 0;
        TX_READY = 1'b0;
        alu_dly = 1;
        exp = alu_fn(ref_a, ref_b, 4'd2);
        put(8'hDD, 0);
        put(8'h02, 0);
        wait_tx();
        TX_READY = 1'b1;
        step();
        TX_READY = 1'b0;
        step();
        chk("pre_rst_hi_vld", 32'(TX_D_VLD), 1);
        chk("pre_rst_hi_data", 32'(TX_P_DATA), 32'(exp[15:8]));
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_vld", 32'(TX_D_VLD), 0);
        chk("async_rst_data", {4'h0, ALU_A, ALU_B, ALU_FUN, TX_P_DATA}, 0);
        chk("async_rst_flags", {27'h0, ALU_EN, ALU_CLK_EN, TX_D_VLD, CMD_ERR, RX_OVERRUN}, 0);
        step(2);
        RST = 1'b0;
        ref_a = '0;
        ref_b = '0;
        rdy_mode = 1;
        step();
        frame(1, 8'h00, 8'h00, 8'h06, 1, 0, 0);
        frame(1, 8'h00, 8'h00, 8'h0A, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int r, d;
            if ($urandom_range(0, 7) == 0) begin
                do c = 8'($urandom); while (c == 8'hCC || c == 8'hDD);
                bad_cmd(c);
            end
            r = $urandom_range(0, 11);
            d = (r == 0) ? 0 : (r == 1) ? 17 : (r == 2) ? 16 : (r == 3) ? $urandom_range(2, 15) : 1;
            frame($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), 8'($urandom), d,
                  $urandom_range(0, 2), $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
- Command-level controller sitting directly upstream of the 16-bit ALU stage and downstream of the RX data path.
- Parses byte frames from the RX side into ALU operands and function, then fires one ALU enable pulse.
- Captures the registered ALU result and serialises it low-byte-first to the TX side over a valid/ready handshake.
- Also drives the clock-gate enable for the ALU domain, for low power.

Parameters:
- DATA_WIDTH, 8, width of RX/TX bytes and ALU operands.
- OUT_WIDTH, 2*DATA_WIDTH, ALU result width.
- CMD_ALU_OP, 8'hCC, frame: CMD, A, B, FUN.
- CMD_ALU_NOP, 8'hDD, frame: CMD, FUN; reuses stored A/B.
- TIMEOUT, 16, max cycles to wait for ALU_OUT_VALID.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- ALU_A  out  DATA_WIDTH  operand A
- ALU_B  out  DATA_WIDTH  operand B
- ALU_FUN  out  4  ALU function code
- ALU_EN  out  1  one-cycle ALU enable
- ALU_CLK_EN  out  1  ALU clock-gate enable
- ALU_OUT  in  OUT_WIDTH  registered ALU result
- ALU_OUT_VALID  in  1  result valid, one cycle after ALU_EN is sampled
- TX_P_DATA  out  DATA_WIDTH  byte to transmit
- TX_D_VLD  out  1  TX byte valid
- TX_READY  in  1  TX can accept a byte
- CMD_ERR  out  1  one-cycle pulse on unknown command or ALU timeout
- RX_OVERRUN  out  1  one-cycle pulse when an RX byte is dropped while busy

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on RST.
- Reset values: all outputs 0; ALU_A/ALU_B/ALU_FUN registers 0; result register 0; state IDLE; timeout counter 0. Every output is registered.
- A reset asserted mid-frame or mid-transmit aborts immediately. No partial byte completes; TX_D_VLD drops asynchronously.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, SEND_LO, SEND_HI.
- IDLE, on RX_D_VLD:
  - CC -> GET_A.
  - DD -> GET_FUN.
  - Any other byte -> stay IDLE, CMD_ERR pulse next cycle.
- GET_A / GET_B / GET_FUN: each waits indefinitely for RX_D_VLD.
  - GET_A latches A, -> GET_B.
  - GET_B latches B, -> GET_FUN.
  - GET_FUN latches RX_P_DATA[3:0] into ALU_FUN, ignores the upper bits, -> ALU_RUN.
- ALU_RUN: lasts exactly 1 cycle. ALU_EN=1 and ALU_CLK_EN=1, then -> ALU_WAIT with counter cleared. ALU_EN is therefore high in the cycle after the FUN byte strobe.
- ALU_WAIT: ALU_CLK_EN=1; counter increments each cycle.
  - On ALU_OUT_VALID: latch ALU_OUT, -> SEND_LO.
  - If the counter reaches TIMEOUT-1 without ALU_OUT_VALID: CMD_ERR pulse, -> IDLE.
  - If ALU_OUT_VALID and timeout coincide, valid wins.
- ALU_CLK_EN is 0 in every other state.
- SEND_LO: TX_D_VLD=1, TX_P_DATA=result[DATA_WIDTH-1:0]. On the edge with TX_D_VLD&&TX_READY -> SEND_HI.
- SEND_HI: TX_D_VLD=1, TX_P_DATA=result[OUT_WIDTH-1:DATA_WIDTH]. On acceptance -> IDLE with TX_D_VLD=0; there is no idle cycle between the two bytes.
- TX_P_DATA is held stable while TX_D_VLD=1 and TX_READY=0.
- Busy drop: RX_D_VLD in ALU_RUN, ALU_WAIT, SEND_LO or SEND_HI drops the byte and pulses RX_OVERRUN next cycle. The FSM is unaffected.
- Operand retention: ALU_A and ALU_B keep their last values across frames. A DD frame reuses them; their value after reset is 0.
- Throughput: minimum frame-to-frame gap is 0 cycles. A new CMD byte is accepted in the cycle after returning to IDLE.

Decomposition:
- Shared package alu_sys_pkg holds:
  - state enum;
  - CMD_ALU_OP and CMD_ALU_NOP;
  - ALU function-code constants: ADD=0, SUB=1, MUL=2, DIV=3, AND=4 … SHL=14.
- Natural sub-module: alu_result_serializer. It owns the result register, SEND_LO/SEND_HI and the TX handshake, with a start/done interface to the FSM.

Test Plan:
- RX CC,12,34,00; ALU model returns 0x0046 one cycle after ALU_EN -> exactly one ALU_EN pulse, ALU_A=0x12, ALU_B=0x34, ALU_FUN=0; TX bytes 0x46 then 0x00.
- RX CC,FF,FF,02; model returns 0xFE01 -> TX 0x01 then 0xFE. Then RX DD,01 -> ALU_A/ALU_B stay 0xFF, ALU_FUN=1; model returns 0x0000 -> TX 0x00,0x00.
- RX 0xAB -> CMD_ERR single pulse, no ALU_EN, stays IDLE. Following CC,05,03,00 (model returns 0x0008) -> TX 0x08,0x00.
- TX_READY held low 10 cycles in SEND_LO -> TX_D_VLD=1 and TX_P_DATA stable throughout. Extra RX byte in that window -> RX_OVERRUN pulse, TX sequence unchanged.
- ALU model never asserts valid -> CMD_ERR after 16 ALU_WAIT cycles, ALU_CLK_EN=0, IDLE; no TX activity.
- RST asserted during SEND_HI -> TX_D_VLD=0 without a clock edge, all outputs at reset values. After release, a DD frame uses A=B=0.
